// File: rtl/window_scan_ctrl.sv
// Stride-2 3x3 window sequencer: fetches nine taps per window into the window file and writes the filtered byte out.
// 11 cycles per output pixel; strobes decode directly from the state registers. start is ignored while a pass runs.
module window_scan_ctrl #(
   parameter int IMG_W    = 5,
   parameter int IMG_H    = 5,
   parameter int ADDR_W   = 16,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 16'h8000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [11:0]       win_sum,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data,
   output logic [3:0]        reg_select,
   output logic              reg_write_en,
   output logic              busy,
   output logic              done
);

   localparam int OUT_W = (IMG_W - 1) / 2;
   localparam int OUT_H = (IMG_H - 1) / 2;
   localparam int OXW   = $clog2(OUT_W + 1);
   localparam int OYW   = $clog2(OUT_H + 1);
   localparam logic [OXW-1:0] OX_LAST = OXW'(OUT_W - 1);
   localparam logic [OYW-1:0] OY_LAST = OYW'(OUT_H - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_LAST  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state;
   logic [OXW-1:0]    ox;
   logic [OYW-1:0]    oy;
   logic [3:0]        c;
   logic [1:0]        tap_r;
   logic [1:0]        tap_q;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic              unused_sum_lsb;

   assign unused_sum_lsb = ^win_sum[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         ox    <= '0;
         oy    <= '0;
         c     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_READ;
                  ox    <= '0;
                  oy    <= '0;
                  c     <= '0;
               end
            end
            S_READ: begin
               if (c == 4'd8) begin
                  state <= S_LAST;
                  c     <= '0;
               end else begin
                  c <= c + 4'd1;
               end
            end
            S_LAST:  state <= S_WRITE;
            S_WRITE: begin
               c <= '0;
               if (ox == OX_LAST) begin
                  ox <= '0;
                  if (oy == OY_LAST) begin
                     oy    <= '0;
                     state <= S_DONE;
                  end else begin
                     oy    <= oy + 1'b1;
                     state <= S_READ;
                  end
               end else begin
                  ox    <= ox + 1'b1;
                  state <= S_READ;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Tap index -> (row, col) inside the window, row-major p1..p9.
   always_comb begin
      {tap_r, tap_q} = 4'b00_00;
      case (c)
         4'd0: {tap_r, tap_q} = 4'b00_00;
         4'd1: {tap_r, tap_q} = 4'b00_01;
         4'd2: {tap_r, tap_q} = 4'b00_10;
         4'd3: {tap_r, tap_q} = 4'b01_00;
         4'd4: {tap_r, tap_q} = 4'b01_01;
         4'd5: {tap_r, tap_q} = 4'b01_10;
         4'd6: {tap_r, tap_q} = 4'b10_00;
         4'd7: {tap_r, tap_q} = 4'b10_01;
         4'd8: {tap_r, tap_q} = 4'b10_10;
         default: {tap_r, tap_q} = 4'b00_00;
      endcase
   end

   assign src_addr = ADDR_W'(SRC_BASE + (2 * int'(oy) + int'(tap_r)) * IMG_W
                             + 2 * int'(ox) + int'(tap_q));
   assign dst_addr = ADDR_W'(DST_BASE + int'(oy) * OUT_W + int'(ox));

   // Each tap is written one cycle after its read, once the memory data is on the bus.
   always_comb begin
      mem_addr     = '0;
      mem_rd_en    = 1'b0;
      mem_wr_en    = 1'b0;
      mem_wr_data  = '0;
      reg_select   = '0;
      reg_write_en = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         S_READ: begin
            busy      = 1'b1;
            mem_rd_en = 1'b1;
            mem_addr  = src_addr;
            if (c != 4'd0) begin
               reg_write_en = 1'b1;
               reg_select   = c - 4'd1;
            end
         end
         S_LAST: begin
            busy         = 1'b1;
            reg_write_en = 1'b1;
            reg_select   = 4'd8;
         end
         S_WRITE: begin
            busy        = 1'b1;
            mem_wr_en   = 1'b1;
            mem_addr    = dst_addr;
            mem_wr_data = win_sum[11:4];
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Bench: two sequencers (5x5 and 7x5) with a byte memory and a 1-2-1 weighted window file around each.
// The expected per-cycle output trace is built from the image and scan rules, then literal values pin key results.
module tb_window_scan_ctrl;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic        we;
      logic        busy;
      logic        done;
      logic [15:0] addr;
      logic [7:0]  wdat;
      logic [3:0]  sel;
   } obs_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  start_s;
   logic [11:0] wsum_a, wsum_b;
   logic [15:0] addr_a, addr_b;
   logic        rd_a, rd_b, wr_a, wr_b, we_a, we_b, busy_a, busy_b, done_a, done_b;
   logic [7:0]  wdat_a, wdat_b;
   logic [3:0]  sel_a, sel_b;

   window_scan_ctrl #(.IMG_W(5), .IMG_H(5)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .win_sum(wsum_a),
      .mem_addr(addr_a), .mem_rd_en(rd_a), .mem_wr_en(wr_a), .mem_wr_data(wdat_a),
      .reg_select(sel_a), .reg_write_en(we_a), .busy(busy_a), .done(done_a));

   window_scan_ctrl #(.IMG_W(7), .IMG_H(5)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .win_sum(wsum_b),
      .mem_addr(addr_b), .mem_rd_en(rd_b), .mem_wr_en(wr_b), .mem_wr_data(wdat_b),
      .reg_select(sel_b), .reg_write_en(we_b), .busy(busy_b), .done(done_b));

   obs_t obs_a, obs_b;
   assign obs_a = {rd_a, wr_a, we_a, busy_a, done_a, addr_a, wdat_a, sel_a};
   assign obs_b = {rd_b, wr_b, we_b, busy_b, done_b, addr_b, wdat_b, sel_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment: registered-read memory, negedge-capturing window file, weighted sum.
   logic [7:0] pix [2][0:63];
   logic [7:0] tap [2][0:8];
   logic [7:0] rdat [2];

   always @(posedge clk) begin
      if (rd_a) rdat[0] <= pix[0][addr_a[5:0]];
      if (rd_b) rdat[1] <= pix[1][addr_b[5:0]];
   end

   always @(negedge clk) begin
      if (we_a && sel_a < 4'd9) tap[0][sel_a] <= rdat[0];
      if (we_b && sel_b < 4'd9) tap[1][sel_b] <= rdat[1];
   end

   function automatic logic [11:0] wsum(input logic [7:0] t0, t1, t2, t3, t4, t5, t6, t7, t8);
      return 12'(int'(t0) + int'(t2) + int'(t6) + int'(t8)
                 + 2 * (int'(t1) + int'(t3) + int'(t5) + int'(t7)) + 4 * int'(t4));
   endfunction

   assign wsum_a = wsum(tap[0][0], tap[0][1], tap[0][2], tap[0][3], tap[0][4],
                        tap[0][5], tap[0][6], tap[0][7], tap[0][8]);
   assign wsum_b = wsum(tap[1][0], tap[1][1], tap[1][2], tap[1][3], tap[1][4],
                        tap[1][5], tap[1][6], tap[1][7], tap[1][8]);

   // Model trace and observation logs.
   obs_t        exp_mem [2][0:127];
   int          exp_len [2];
   int          exp_pos [2];
   int          samp [2];
   int          wr_cnt [2];
   int          rd_cnt [2];
   int          done_at [2];
   logic [15:0] wr_addr_log [2][0:15];
   logic [7:0]  wr_dat_log [2][0:15];
   logic [15:0] rd_log [2][0:127];
   int          checks = 0;
   int          errors = 0;
   int          win10 [9] = '{2, 3, 4, 7, 8, 9, 12, 13, 14};

   task automatic build_trace(input int w, input int iw, input int ih);
      int ow, oh, n, sum, a, kw;
      obs_t e;
      ow = (iw - 1) / 2;
      oh = (ih - 1) / 2;
      n  = 0;
      for (int oy = 0; oy < oh; oy++) begin
         for (int ox = 0; ox < ow; ox++) begin
            sum = 0;
            for (int k = 0; k < 10; k++) begin
               e = '0;
               e.busy = 1'b1;
               if (k < 9) begin
                  a = (2 * oy + k / 3) * iw + 2 * ox + k % 3;
                  kw = (k == 4) ? 4 : ((k % 2 == 1) ? 2 : 1);
                  sum += kw * int'(pix[w][a]);
                  e.rd = 1'b1;
                  e.addr = 16'(a);
               end
               if (k >= 1) begin
                  e.we = 1'b1;
                  e.sel = 4'(k - 1);
               end
               exp_mem[w][n] = e;
               n++;
            end
            e = '0;
            e.busy = 1'b1;
            e.wr = 1'b1;
            e.addr = 16'(32'h8000 + oy * ow + ox);
            e.wdat = 8'(sum / 16);
            exp_mem[w][n] = e;
            n++;
         end
      end
      e = '0;
      e.done = 1'b1;
      exp_mem[w][n] = e;
      exp_len[w] = n + 1;
      exp_pos[w] = 0;
      samp[w] = 0;
      wr_cnt[w] = 0;
      rd_cnt[w] = 0;
      done_at[w] = -1;
   endtask

   task automatic check_one(input int w, input obs_t act);
      obs_t e;
      samp[w]++;
      e = '0;
      if (exp_pos[w] < exp_len[w]) begin
         e = exp_mem[w][exp_pos[w]];
         exp_pos[w]++;
      end
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL trace dut%0d sample %0d: got rd=%b wr=%b we=%b busy=%b done=%b addr=%h wdat=%0d sel=%0d, expected rd=%b wr=%b we=%b busy=%b done=%b addr=%h wdat=%0d sel=%0d",
                  w, samp[w], act.rd, act.wr, act.we, act.busy, act.done, act.addr, act.wdat, act.sel,
                  e.rd, e.wr, e.we, e.busy, e.done, e.addr, e.wdat, e.sel);
      end
      if (act.wr === 1'b1) begin
         if (wr_cnt[w] < 16) begin
            wr_addr_log[w][wr_cnt[w]] = act.addr;
            wr_dat_log[w][wr_cnt[w]] = act.wdat;
         end
         wr_cnt[w]++;
      end
      if (act.rd === 1'b1) begin
         if (rd_cnt[w] < 128) rd_log[w][rd_cnt[w]] = act.addr;
         rd_cnt[w]++;
      end
      if (act.done === 1'b1 && done_at[w] < 0) done_at[w] = samp[w];
   endtask

   always @(posedge clk) begin
      #2;
      check_one(0, obs_a);
      check_one(1, obs_b);
   end

   task automatic lit(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fill(input int w, input logic [7:0] v);
      for (int i = 0; i < 64; i++) pix[w][i] = v;
   endtask

   // Extra start pulses land in READ/WRITE/DONE cycles of a 5x5 pass.
   task automatic run_pass(input int w, input int iw, input int ih, input bit noise);
      @(negedge clk);
      build_trace(w, iw, ih);
      start_s[w] = 1'b1;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         start_s[w] = noise && (n == 5 || n == 20 || n == 44 || n == 45);
         if (exp_pos[w] >= exp_len[w]) break;
      end
      checks++;
      if (exp_pos[w] < exp_len[w]) begin
         errors++;
         $display("FAIL pass_timeout dut%0d: consumed %0d of %0d trace entries", w, exp_pos[w], exp_len[w]);
         exp_len[w] = exp_pos[w];
      end
      @(negedge clk);
      start_s[w] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1;
      start_s = 2'b00;
      for (int w = 0; w < 2; w++) begin
         exp_len[w] = 0;
         exp_pos[w] = 0;
         samp[w] = 0;
         wr_cnt[w] = 0;
         rd_cnt[w] = 0;
         done_at[w] = -1;
         fill(w, 8'd0);
      end
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      lit("reset_busy", int'(busy_a), 0);
      lit("reset_rd_en", int'(rd_a), 0);
      lit("reset_addr", int'(addr_a), 0);
      lit("reset_done_b", int'(done_b), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      fill(0, 8'd100);
      run_pass(0, 5, 5, 1'b0);
      lit("flat100_writes", wr_cnt[0], 4);
      for (int i = 0; i < 4; i++) begin
         lit("flat100_addr", int'(wr_addr_log[0][i]), 32'h8000 + i);
         lit("flat100_data", int'(wr_dat_log[0][i]), 100);
      end
      lit("flat100_done_cycle", done_at[0], 45);
      for (int i = 0; i < 9; i++) lit("win10_read_addr", int'(rd_log[0][9 + i]), win10[i]);

      fill(0, 8'd0);
      pix[0][12] = 8'd160;
      run_pass(0, 5, 5, 1'b0);
      for (int i = 0; i < 4; i++) lit("corner_tap_data", int'(wr_dat_log[0][i]), 10);

      fill(0, 8'd0);
      pix[0][6] = 8'd160;
      run_pass(0, 5, 5, 1'b0);
      lit("center_tap_out0", int'(wr_dat_log[0][0]), 40);
      for (int i = 1; i < 4; i++) lit("center_tap_others", int'(wr_dat_log[0][i]), 0);

      fill(0, 8'd255);
      run_pass(0, 5, 5, 1'b1);
      lit("sat255_writes", wr_cnt[0], 4);
      for (int i = 0; i < 4; i++) lit("sat255_data", int'(wr_dat_log[0][i]), 255);

      // Abandon a pass mid-READ with reset.
      fill(0, 8'd100);
      @(negedge clk);
      build_trace(0, 5, 5);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (3) @(negedge clk);
      exp_len[0] = exp_pos[0];
      rst_n = 1'b0;
      #1;
      lit("midreset_rd_en", int'(rd_a), 0);
      lit("midreset_we", int'(we_a), 0);
      lit("midreset_busy", int'(busy_a), 0);
      lit("midreset_addr", int'(addr_a), 0);
      wr_cnt[0] = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      lit("midreset_no_writes", wr_cnt[0], 0);

      for (int i = 0; i < 64; i++) pix[1][i] = 8'($urandom_range(0, 255));
      run_pass(1, 7, 5, 1'b0);
      lit("wide_writes", wr_cnt[1], 6);
      lit("wide_last_addr", int'(wr_addr_log[1][5]), 32'h8005);
      lit("wide_done_cycle", done_at[1], 67);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

endmodule
